header_assembler: RTL and testbench

- Sits directly downstream of the work FIFO in the miner datapath.
- Pops DATA_SIZE-bit words from the FIFO read port and packs WORDS consecutive words into one block-header vector.
- Hands the vector to the hash core over a valid/ready handshake.
- A partial header left stalled by a timeout, or cleared by a flush, is discarded so the stream re-aligns.

---
 rtl/header_assembler.sv | 122 ++++++++++++
 tb/tb_header_assembler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_assembler.sv
// Packs WORDS consecutive FIFO words into one block header and presents it to
// the hash core; partial headers are discarded on idle timeout or on clr.
module header_assembler #(
    parameter int WORDS     = 20,
    parameter int DATA_SIZE = 32,
    parameter int TIMEOUT   = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       fifo_rd,
    input  logic                       fifo_empty,
    input  logic [DATA_SIZE-1:0]       fifo_dout,
    input  logic                       clr,
    output logic                       hdr_valid,
    input  logic                       hdr_ready,
    output logic [WORDS*DATA_SIZE-1:0] hdr_data,
    output logic [$clog2(WORDS+1)-1:0] word_cnt,
    output logic                       err,
    output logic                       dbg_state
);

    localparam int HW = WORDS * DATA_SIZE;
    localparam int CW = $clog2(WORDS + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TIMER_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] WORDS_C    = CW'(WORDS);
    localparam logic [CW-1:0] WORDS_M1   = CW'(WORDS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        FILL    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   issued_q, issued_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rd_q, rd_d;
    logic [HW-1:0]   data_q, data_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            partial;
    logic            fire;

    // Handshake: the header transfers in a cycle where hdr_valid and hdr_ready
    // are both high. hdr_valid is decoded from state only, so it never depends
    // on hdr_ready; once raised it holds, with hdr_data stable, until that cycle.
    always_comb begin
        partial = (state_q == FILL) && (issued_q != '0) && (issued_q < WORDS_C);
        fifo_rd = (state_q == FILL) && !fifo_empty && (issued_q < WORDS_C) && !rst && !clr;
        // The timer value counts completed idle cycles, so this idle cycle is the TIMEOUT-th.
        fire    = TIMER_EN && partial && !fifo_rd && !rst && !clr && (timer_q == TIMER_LAST);
        err     = fire;

        state_d  = state_q;
        issued_d = issued_q;
        cnt_d    = cnt_q;
        rd_d     = fifo_rd;
        data_d   = data_q;
        timer_d  = timer_q;

        if (clr || fire) begin
            // A word popped last cycle is still in flight; dropping rd_d discards it.
            state_d  = FILL;
            issued_d = '0;
            cnt_d    = '0;
            rd_d     = 1'b0;
            timer_d  = '0;
        end else if (state_q == PRESENT) begin
            timer_d = '0;
            if (hdr_ready) begin
                state_d  = FILL;
                issued_d = '0;
                cnt_d    = '0;
            end
        end else begin
            if (rd_q) begin
                data_d = (data_q << DATA_SIZE) | HW'(fifo_dout);
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == WORDS_M1) begin
                    state_d = PRESENT;
                end
            end
            if (fifo_rd) begin
                issued_d = issued_q + 1'b1;
                timer_d  = '0;
            end else if (partial && TIMER_EN) begin
                timer_d = timer_q + 1'b1;
            end else begin
                timer_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            issued_q <= '0;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            data_q   <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            timer_q  <= timer_d;
        end
    end

    assign hdr_valid = (state_q == PRESENT);
    assign hdr_data  = data_q;
    assign word_cnt  = cnt_q;
    assign dbg_state = (state_q == PRESENT);

    a_pop_not_empty : assert property (@(posedge clk) disable iff (rst) fifo_rd |-> !fifo_empty);
    a_valid_full    : assert property (@(posedge clk) disable iff (rst) hdr_valid |-> (word_cnt == WORDS_C));
    a_issued_bound  : assert property (@(posedge clk) disable iff (rst) issued_q <= WORDS_C);

endmodule

// File: tb/tb_header_assembler.sv
// Bench for header_assembler: bench-side FIFO, cycle-level reference model of
// the header rules, header scoreboard and a one-line summary.
module tb_header_assembler;

    localparam int WORDS     = 20;
    localparam int DATA_SIZE = 32;
    localparam int TIMEOUT   = 8;
    localparam int HW        = WORDS * DATA_SIZE;
    localparam int CW        = $clog2(WORDS + 1);

    // ---------------- clock / reset / DUT ----------------
    logic                 clk        = 1'b0;
    logic                 rst        = 1'b1;
    logic                 clr        = 1'b0;
    logic                 hdr_ready  = 1'b0;
    logic                 fifo_empty = 1'b1;
    logic [DATA_SIZE-1:0] fifo_dout  = '0;
    logic                 fifo_rd;
    logic                 hdr_valid;
    logic                 err;
    logic                 dbg_state;
    logic [HW-1:0]        hdr_data;
    logic [CW-1:0]        word_cnt;

    header_assembler #(
        .WORDS(WORDS),
        .DATA_SIZE(DATA_SIZE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_rd(fifo_rd),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .clr(clr),
        .hdr_valid(hdr_valid),
        .hdr_ready(hdr_ready),
        .hdr_data(hdr_data),
        .word_cnt(word_cnt),
        .err(err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=still_running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bench FIFO and model state ----------------
    logic [DATA_SIZE-1:0] fifo_q[$];
    logic                 gate = 1'b0;

    int                   m_issued, m_cnt, m_idle;
    bit                   m_present, m_inflight;
    bit                   m_zero = 1'b1;
    logic [DATA_SIZE-1:0] m_inflight_word;
    logic [DATA_SIZE-1:0] m_words[$];
    logic [HW-1:0]        exp_q[$];

    int n_checks, n_errors;
    int cyc, pops, last_pop_cyc, err_cyc, err_cnt, delivered;
    bit last_rd;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Header as the spec defines it: first captured word in the top slot.
    function automatic logic [HW-1:0] assemble();
        logic [HW-1:0] h;
        h = '0;
        for (int i = 0; i < m_words.size(); i++) begin
            h[HW-1-i*DATA_SIZE -: DATA_SIZE] = m_words[i];
        end
        return h;
    endfunction

    task automatic model_clear();
        if (m_present) void'(exp_q.pop_back());
        m_issued   = 0;
        m_cnt      = 0;
        m_idle     = 0;
        m_present  = 1'b0;
        m_inflight = 1'b0;
        m_words.delete();
    endtask

    // ---------------- one clock cycle (entered and left at negedge) ----------------
    task automatic cycle();
        bit                   exp_rd, exp_err, rd_now;
        logic [DATA_SIZE-1:0] head, w;
        logic [HW-1:0]        h;
        fifo_empty = gate || (fifo_q.size() == 0);
        head = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        #1;
        exp_rd  = !rst && !clr && !m_present && !fifo_empty && (m_issued < WORDS);
        exp_err = !rst && !clr && !m_present && (m_issued > 0) && (m_issued < WORDS) &&
                  !exp_rd && (m_idle == TIMEOUT - 1);

        check("fifo_rd", HW'(fifo_rd), HW'(exp_rd));
        check("err", HW'(err), HW'(exp_err));
        check("hdr_valid", HW'(hdr_valid), HW'(m_present));
        check("dbg_state", HW'(dbg_state), HW'(m_present));
        check("word_cnt", HW'(word_cnt), HW'(m_cnt));
        if (m_present) check("hdr_data", hdr_data, assemble());
        else if (m_zero) check("hdr_data_zero", hdr_data, '0);

        if (m_present && hdr_ready && !clr && !rst) begin
            h = exp_q.pop_front();
            check("handshake_hdr", hdr_data, h);
            delivered++;
        end

        rd_now  = fifo_rd;
        last_rd = fifo_rd;
        w = '0;
        if (rd_now) begin
            pops++;
            last_pop_cyc = cyc;
            if (fifo_q.size() > 0) w = fifo_q.pop_front();
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end

        if (rst) begin
            model_clear();
            m_zero = 1'b1;
        end else if (clr || exp_err) begin
            model_clear();
        end else if (m_present) begin
            m_idle = 0;
            if (hdr_ready) begin
                m_present = 1'b0;
                m_cnt     = 0;
                m_issued  = 0;
                m_words.delete();
            end
        end else begin
            if (m_inflight) begin
                m_words.push_back(m_inflight_word);
                m_cnt++;
                m_zero = 1'b0;
                if (m_cnt == WORDS) begin
                    m_present = 1'b1;
                    exp_q.push_back(assemble());
                end
            end
            if (exp_rd) begin
                m_issued++;
                m_idle          = 0;
                m_inflight      = 1'b1;
                m_inflight_word = head;
            end else begin
                m_inflight = 1'b0;
                m_idle     = (m_issued > 0 && m_issued < WORDS) ? m_idle + 1 : 0;
            end
        end

        @(posedge clk);
        @(negedge clk);
        if (rd_now) fifo_dout = w;
        cyc++;
    endtask

    task automatic wait_present(input string tag, input int budget);
        int n;
        n = 0;
        while (!m_present && n < budget) begin
            cycle();
            n++;
        end
        check(tag, HW'(m_present), HW'(1));
    endtask

    task automatic handshake();
        hdr_ready = 1'b1;
        cycle();
        hdr_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_SIZE-1:0] s2_first;
        logic [DATA_SIZE-1:0] s3_words[$];
        logic [HW-1:0]        s5_hdr;
        bit                   done, found;
        int                   n, p0;

        @(negedge clk);
        repeat (3) cycle();
        rst = 1'b0;
        check("rst_word_cnt", HW'(word_cnt), HW'(0));
        check("rst_hdr_data", hdr_data, '0);

        // Back-to-back fill with 1..20, plus 25 words queued behind it.
        for (int i = 1; i <= WORDS; i++) fifo_q.push_back(DATA_SIZE'(i));
        for (int i = 0; i < 25; i++) fifo_q.push_back($urandom);
        pops = 0;
        wait_present("s1_present", 40);
        check("s1_pops", HW'(pops), HW'(WORDS));
        check("s1_valid_lag", HW'(cyc - last_pop_cyc), HW'(2));
        check("s1_hdr_valid", HW'(hdr_valid), HW'(1));
        check("s1_msw", HW'(hdr_data[HW-1 -: DATA_SIZE]), HW'(32'h1));
        check("s1_lsw", HW'(hdr_data[DATA_SIZE-1:0]), HW'(32'h14));
        check("s1_word_cnt", HW'(word_cnt), HW'(WORDS));

        // Back-pressure: no pops and stable header for 50 cycles.
        p0 = pops;
        repeat (50) cycle();
        check("s1_no_pops_stalled", HW'(pops - p0), HW'(0));
        handshake();
        check("s1_valid_drop", HW'(hdr_valid), HW'(0));
        p0 = pops;
        cycle();
        check("s1_resume", HW'(pops - p0), HW'(1));

        // Timeout: five pops, then stall.
        n = 0;
        while (m_issued < 5 && n < 20) begin
            cycle();
            n++;
        end
        gate    = 1'b1;
        err_cnt = 0;
        repeat (12) cycle();
        check("s2_err_count", HW'(err_cnt), HW'(1));
        check("s2_err_delay", HW'(err_cyc - last_pop_cyc), HW'(TIMEOUT));
        check("s2_word_cnt", HW'(word_cnt), HW'(0));
        s2_first = fifo_q[0];
        gate = 1'b0;
        wait_present("s2_present", 60);
        check("s2_first_word", HW'(hdr_data[HW-1 -: DATA_SIZE]), HW'(s2_first));
        handshake();

        // clr in the capture cycle that would make word_cnt 4.
        for (int i = 0; i < 10; i++) begin
            s3_words.push_back($urandom);
            fifo_q.push_back(s3_words[i]);
        end
        done = 1'b0;
        n    = 0;
        while (!done && n < 40) begin
            clr = (m_cnt == 3) && m_inflight;
            cycle();
            if (clr) begin
                done = 1'b1;
                check("s3_word_cnt", HW'(word_cnt), HW'(0));
            end
            clr = 1'b0;
            n++;
        end
        check("s3_clr_issued", HW'(done), HW'(1));
        for (int i = 0; i < 14; i++) fifo_q.push_back($urandom);
        wait_present("s3_present", 60);
        check("s3_first_word", HW'(hdr_data[HW-1 -: DATA_SIZE]), HW'(s3_words[4]));
        found = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            if (hdr_data[i*DATA_SIZE +: DATA_SIZE] == s3_words[3]) found = 1'b1;
        end
        check("s3_dropped_absent", HW'(found), HW'(0));
        handshake();

        // rst mid-fill, then rst while presenting.
        for (int i = 0; i < 35; i++) fifo_q.push_back($urandom);
        n = 0;
        while (m_cnt < 10 && n < 40) begin
            cycle();
            n++;
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("s4a_rd_in_rst", HW'(last_rd), HW'(0));
        check("s4a_word_cnt", HW'(word_cnt), HW'(0));
        check("s4a_hdr_valid", HW'(hdr_valid), HW'(0));
        check("s4a_hdr_data", hdr_data, '0);
        check("s4a_err", HW'(err), HW'(0));
        wait_present("s4_present", 60);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        fifo_q.delete();
        check("s4b_rd_in_rst", HW'(last_rd), HW'(0));
        check("s4b_word_cnt", HW'(word_cnt), HW'(0));
        check("s4b_hdr_valid", HW'(hdr_valid), HW'(0));
        check("s4b_hdr_data", hdr_data, '0);

        // Intermittent FIFO: empty toggles every cycle.
        s5_hdr = '0;
        for (int i = 0; i < WORDS; i++) begin
            logic [DATA_SIZE-1:0] v;
            v = $urandom;
            fifo_q.push_back(v);
            s5_hdr[HW-1-i*DATA_SIZE -: DATA_SIZE] = v;
        end
        n = 0;
        while (!m_present && n < 80) begin
            gate = (cyc % 2 == 1);
            cycle();
            n++;
        end
        gate = 1'b0;
        check("s5_present", HW'(m_present), HW'(1));
        check("s5_header", hdr_data, s5_hdr);
        handshake();

        // Random traffic with back-pressure, flushes and forced long stalls.
        delivered = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 1) == 1 && fifo_q.size() < 40) fifo_q.push_back($urandom);
            gate      = (k % 100 >= 85) ? 1'b1 : ($urandom_range(0, 4) == 0);
            hdr_ready = ($urandom_range(0, 2) == 0);
            clr       = ($urandom_range(0, 60) == 0);
            cycle();
        end
        clr       = 1'b0;
        hdr_ready = 1'b0;
        gate      = 1'b0;
        check("s6_some_delivered", HW'(delivered > 0), HW'(1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
